uart_mem_txbuf: RTL and testbench
=================================

# uart_mem_txbuf

Write-buffering bridge between the CPU memory bus and the UART register slave. CPU writes to UART_DATA go into a local byte FIFO and complete without waiting for the serial line. A drain engine replays the buffered bytes into the UART slave one at a time. Divisor writes and data reads are forwarded, and a local STATUS register exposes FIFO state.

## Interface
- `DEPTH`, default 16: TX FIFO depth in bytes; power of two, minimum 2.
- `LVL_W`, default $clog2(DEPTH)+1: width of the FIFO level counter.
- `clk`  in  1  system clock.
- `rstn`  in  1  synchronous active-low reset.
- `s_mem_valid`  in  1  CPU-side request.
- `s_mem_ready`  out  1  CPU-side completion, one-cycle pulse.
- `s_mem_addr`  in  32  CPU address; only bits [3:2] are decoded.
- `s_mem_wdata`  in  32  CPU write data.
- `s_mem_wstrb`  in  4  CPU byte strobes; all zero means read.
- `s_mem_rdata`  out  32  CPU read data, valid while s_mem_ready=1.
- `m_mem_valid`  out  1  request to the UART slave.
- `m_mem_ready`  in  1  UART slave completion.
- `m_mem_addr`  out  32  UART address (0x0 = DIV, 0x4 = DATA).
- `m_mem_wdata`  out  32  UART write data.
- `m_mem_wstrb`  out  4  UART byte strobes.
- `m_mem_rdata`  in  32  UART read data.

## Operation
Address map, decoded from s_mem_addr[3:2]:
- 00: DIV, forwarded to the UART.
- 01: DATA. A write with wstrb[0]=1 is buffered in the FIFO; a read is forwarded.
- 10: STATUS, local and read-only; rdata = {zero pad, level[LVL_W-1:0], full, empty}, with empty in bit 0.
- 11: reserved. Reads return 0; writes are ignored; ready is given in the same cycle.

Buffered data write:
- If the FIFO is not full: push wdata[7:0]; s_mem_ready=1 in the same cycle.
- If the FIFO is full: s_mem_ready stays 0 until a pop frees a slot; the push and ready then occur in the cycle the slot is free.
- A DATA write with wstrb[0]=0 completes immediately with no effect.

Forwarded access (DIV write, DATA read, DIV read) is called a pending pass.
- A DIV write is not forwarded until the FIFO is empty and the state is IDLE. This prevents a divisor change mid-stream.

State machine:
- IDLE
  - If a pass is pending and eligible -> PASS.
  - Else if the FIFO is non-empty -> DRAIN.
  - Pass has priority over drain.
- PASS
  - m_mem_valid = s_mem_valid, and addr/wdata/wstrb pass straight through from the CPU side.
  - s_mem_ready = m_mem_ready; s_mem_rdata = m_mem_rdata.
  - On m_mem_ready -> IDLE.
- DRAIN
  - m_mem_valid=1, m_mem_addr=0x4, m_mem_wdata={24'b0, head}, m_mem_wstrb=4'b0001.
  - Outputs are held stable until m_mem_ready.
  - On m_mem_ready: pop the head and go to IDLE.
- Outside PASS and DRAIN: m_mem_valid=0, m_mem_addr/wdata/wstrb=0.

Boundary conditions:
- Simultaneous push and pop: level is unchanged, and a full FIFO accepts the push.
- Read and write pointers wrap modulo DEPTH.
- level counts from 0 to DEPTH inclusive.
- Reset mid-operation:
  - FIFO is emptied and state returns to IDLE with m_mem_valid=0.
  - Bytes already in the UART shifter are not recalled.

## Timing
- Reset values:
  - s_mem_ready=0, s_mem_rdata=0.
  - m_mem_valid=0, m_mem_addr/wdata/wstrb=0.
  - level=0, empty=1, full=0, state=IDLE.
- Latency:
  - Buffered write and STATUS read: 0 extra cycles.
  - Pass: 1 cycle (IDLE->PASS) plus the UART slave latency.
  - Drain: one byte per DRAIN visit. There is at least one IDLE cycle between consecutive bytes.
- CPU rule: s_mem_valid is held until s_mem_ready. Each accepted request gets exactly one ready pulse, and a held valid is never double-pushed.
- UART rule: m_mem_valid and the payload stay constant from assertion until the m_mem_ready cycle.

## Structure
- Package `uart_txbuf_pkg` holds:
  - Address constants: ADDR_DIV=2'b00, ADDR_DATA=2'b01, ADDR_STATUS=2'b10.
  - UART offsets: 0x0, 0x4.
  - State enum {IDLE, PASS, DRAIN}.
- Sub-module `uart_txbuf_fifo`:
  - Synchronous byte FIFO with push/pop/full/empty/level.
  - Parameter DEPTH; same clock and reset.
- Top level: address decode, arbitration FSM, output muxing.

## Test plan
- Reset, then read STATUS -> rdata=0x1 (empty, level 0); m_mem_valid never asserts.
- Write 0x41, 0x42, 0x43 to DATA with the slave holding ready low for 10 cycles per byte -> three same-cycle CPU readies. The slave then sees three writes at 0x4 with wdata 0x41, 0x42, 0x43 in order and wstrb=0001.
- Fill 16 bytes with the slave stalled:
  - STATUS shows level 16 and full.
  - A 17th write stalls.
  - When the slave completes one byte, the 17th is accepted in the pop cycle and level stays 16.
- With 2 bytes queued, write DIV=0x1B2 -> both bytes drain first, then the slave sees one write at 0x0 with wdata 0x1B2 and wstrb 1111; the CPU ready coincides with m_mem_ready.
- DATA read with the FIFO non-empty and the drain idle -> PASS is chosen before DRAIN; the CPU receives slave rdata 0x55.
- Assert rstn=0 mid-DRAIN with 5 bytes queued -> the next cycle shows m_mem_valid=0 and STATUS=0x1; no further slave writes occur.

Source files
------------

// File: rtl/uart_txbuf_pkg.sv
// Shared definitions for the UART write-buffering bridge.
//   - CPU-side address decode values (s_mem_addr[3:2])
//   - UART slave register offsets
//   - Arbitration FSM state encoding
package uart_txbuf_pkg;

  localparam logic [1:0] ADDR_DIV    = 2'b00;
  localparam logic [1:0] ADDR_DATA   = 2'b01;
  localparam logic [1:0] ADDR_STATUS = 2'b10;
  localparam logic [1:0] ADDR_RSVD   = 2'b11;

  localparam logic [31:0] UART_OFF_DIV  = 32'h0;
  localparam logic [31:0] UART_OFF_DATA = 32'h4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/uart_txbuf_fifo.sv
// Synchronous byte FIFO holding buffered UART TX data.
// Ports:
//   clk, rstn   clock and synchronous active-low reset
//   push, din   write request and byte; dropped when full unless popping
//   pop         read request; ignored when empty
//   dout        head byte (valid while !empty)
//   full, empty occupancy flags
//   level       occupancy count, 0..DEPTH inclusive
module uart_txbuf_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; contents are only
  // observable through the pointers, which are reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_mem_txbuf.sv
// Write-buffering bridge between the CPU memory bus and the UART slave.
// DATA writes are queued in a local FIFO and complete at once; a drain engine
// replays them to the UART. DIV accesses and DATA reads are forwarded (PASS).
// Ports:
//   clk, rstn                 clock and synchronous active-low reset
//   s_mem_valid/ready         CPU request / one-cycle completion pulse
//   s_mem_addr/wdata/wstrb    CPU request payload ([3:2] decoded; wstrb=0 is read)
//   s_mem_rdata               CPU read data, valid with s_mem_ready
//   m_mem_valid/ready         UART slave request / completion
//   m_mem_addr/wdata/wstrb    UART request payload
//   m_mem_rdata               UART read data
module uart_mem_txbuf
  import uart_txbuf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_mem_valid,
  output logic        s_mem_ready,
  input  logic [31:0] s_mem_addr,
  input  logic [31:0] s_mem_wdata,
  input  logic [3:0]  s_mem_wstrb,
  output logic [31:0] s_mem_rdata,
  output logic        m_mem_valid,
  input  logic        m_mem_ready,
  output logic [31:0] m_mem_addr,
  output logic [31:0] m_mem_wdata,
  output logic [3:0]  m_mem_wstrb,
  input  logic [31:0] m_mem_rdata
);

  state_e           state;
  state_e           state_nxt;
  logic [1:0]       sel;
  logic             is_wr;
  logic             data_wr;
  logic             pass_req;
  logic             pass_ok;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       fifo_head;
  logic [31:0]      status_word;

  assign sel     = s_mem_addr[3:2];
  assign is_wr   = |s_mem_wstrb;
  assign data_wr = s_mem_valid && (sel == ADDR_DATA) && is_wr;

  // DIV reads/writes and DATA reads go to the UART. A DIV write waits for an
  // empty FIFO so the baud rate never changes under queued bytes.
  assign pass_req = s_mem_valid &&
                    ((sel == ADDR_DIV) || ((sel == ADDR_DATA) && !is_wr));
  assign pass_ok  = pass_req && (!((sel == ADDR_DIV) && is_wr) || fifo_empty);

  assign pop  = (state == DRAIN) && m_mem_ready;
  assign push = data_wr && s_mem_wstrb[0] && (!fifo_full || pop);

  assign status_word = {{(30 - LVL_W){1'b0}}, fifo_level, fifo_full, fifo_empty};

  uart_txbuf_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (s_mem_wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt   = state;
    m_mem_valid = 1'b0;
    m_mem_addr  = '0;
    m_mem_wdata = '0;
    m_mem_wstrb = '0;
    s_mem_ready = 1'b0;
    s_mem_rdata = '0;

    case (state)
      IDLE: begin
        if (pass_ok)          state_nxt = PASS;
        else if (!fifo_empty) state_nxt = DRAIN;
      end
      PASS: begin
        m_mem_valid = s_mem_valid;
        m_mem_addr  = s_mem_addr;
        m_mem_wdata = s_mem_wdata;
        m_mem_wstrb = s_mem_wstrb;
        s_mem_ready = m_mem_ready;
        s_mem_rdata = m_mem_rdata;
        if (m_mem_ready) state_nxt = IDLE;
      end
      DRAIN: begin
        // Head is stable here: only a pop moves rd_ptr.
        m_mem_valid = 1'b1;
        m_mem_addr  = UART_OFF_DATA;
        m_mem_wdata = {24'b0, fifo_head};
        m_mem_wstrb = 4'b0001;
        if (m_mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Locally completed requests. A forwarded request is always in flight
    // during PASS, so these never collide with the pass-through ready.
    if (state != PASS && s_mem_valid) begin
      if (push) begin
        s_mem_ready = 1'b1;
      end else if (data_wr && !s_mem_wstrb[0]) begin
        s_mem_ready = 1'b1;
      end else if (sel == ADDR_STATUS) begin
        s_mem_ready = 1'b1;
        if (!is_wr) s_mem_rdata = status_word;
      end else if (sel == ADDR_RSVD) begin
        s_mem_ready = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_txbuf.sv
// Directed self-checking bench for uart_mem_txbuf (DEPTH=16, LVL_W=5).
// A behavioural UART slave with programmable latency logs every completed
// transfer; expected values are hand-computed constants.
module tb_uart_mem_txbuf;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_mem_valid = 1'b0;
  logic        s_mem_ready;
  logic [31:0] s_mem_addr = '0;
  logic [31:0] s_mem_wdata = '0;
  logic [3:0]  s_mem_wstrb = '0;
  logic [31:0] s_mem_rdata;
  logic        m_mem_valid;
  logic        m_mem_ready = 1'b0;
  logic [31:0] m_mem_addr;
  logic [31:0] m_mem_wdata;
  logic [3:0]  m_mem_wstrb;
  logic [31:0] m_mem_rdata = '0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } xact_t;

  xact_t       log_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          stab_err = 0;
  bit          saw_valid = 1'b0;
  bit          slave_hold = 1'b0;
  int          slave_lat = 0;
  int          wait_cnt = 0;
  logic [31:0] rd;
  int          w;
  logic        mr;

  localparam logic [31:0] A_DIV = 32'h0, A_DATA = 32'h4, A_STAT = 32'h8, A_RSVD = 32'hC;

  uart_mem_txbuf #(.DEPTH(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_mem_valid (s_mem_valid),
    .s_mem_ready (s_mem_ready),
    .s_mem_addr  (s_mem_addr),
    .s_mem_wdata (s_mem_wdata),
    .s_mem_wstrb (s_mem_wstrb),
    .s_mem_rdata (s_mem_rdata),
    .m_mem_valid (m_mem_valid),
    .m_mem_ready (m_mem_ready),
    .m_mem_addr  (m_mem_addr),
    .m_mem_wdata (m_mem_wdata),
    .m_mem_wstrb (m_mem_wstrb),
    .m_mem_rdata (m_mem_rdata)
  );

  initial forever #5 clk = ~clk;

  // UART slave: raises ready after slave_lat waiting cycles, for one cycle.
  initial forever begin
    @(posedge clk);
    #2;
    if (m_mem_ready) begin
      m_mem_ready = 1'b0;
      wait_cnt    = 0;
    end else if (!m_mem_valid) begin
      wait_cnt = 0;
    end else if (!slave_hold) begin
      if (wait_cnt >= slave_lat) m_mem_ready = 1'b1;
      else                       wait_cnt++;
    end
  end

  // Monitor: logs completions, flags any valid, and checks payload stability.
  initial begin
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [67:0] pp = '0;
    forever begin
      @(negedge clk);
      if (m_mem_valid) saw_valid = 1'b1;
      if (m_mem_valid && pv && !pr && ({m_mem_addr, m_mem_wdata, m_mem_wstrb} !== pp))
        stab_err++;
      if (m_mem_valid && m_mem_ready)
        log_q.push_back('{addr: m_mem_addr, wdata: m_mem_wdata, wstrb: m_mem_wstrb});
      pv = m_mem_valid;
      pr = m_mem_ready;
      pp = {m_mem_addr, m_mem_wdata, m_mem_wstrb};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU transfer, started and ended at #1 after a rising edge.
  task automatic cpu_xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata,
                          output int waits, output logic mready);
    bit done = 1'b0;
    s_mem_valid = 1'b1;
    s_mem_addr  = addr;
    s_mem_wdata = wdata;
    s_mem_wstrb = wstrb;
    waits  = 0;
    rdata  = '0;
    mready = 1'b0;
    while (!done && waits < 200) begin
      @(negedge clk);
      if (s_mem_ready) begin
        done   = 1'b1;
        rdata  = s_mem_rdata;
        mready = m_mem_ready;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    s_mem_valid = 1'b0;
    s_mem_addr  = '0;
    s_mem_wdata = '0;
    s_mem_wstrb = '0;
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic cpu_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    logic [31:0] r;
    int          k;
    logic        m;
    cpu_xfer(tag, addr, data, strb, r, k, m);
    check({tag, "_waits"}, 32'(k), 32'd0);
  endtask

  task automatic cpu_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    int          k;
    logic        m;
    cpu_xfer(tag, addr, 32'h0, 4'b0000, r, k, m);
    check({tag, "_rdata"}, r, exp);
  endtask

  task automatic wait_log(input string tag, input int n, input int bound);
    int k = 0;
    while (log_q.size() < n && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, 32'(log_q.size()), 32'(n));
  endtask

  initial begin
    // ---- Reset ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_mem_ready), 32'd0);
    check("rst_s_rdata", s_mem_rdata, 32'd0);
    check("rst_m_valid", 32'(m_mem_valid), 32'd0);
    check("rst_m_payload", m_mem_addr | m_mem_wdata | 32'(m_mem_wstrb), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cpu_read("stat_reset", A_STAT, 32'h1);

    // ---- Reserved and no-strobe DATA write ----
    cpu_write("rsvd_wr", A_RSVD, 32'hFFFF_FFFF, 4'b1111);
    cpu_read("rsvd_rd", A_RSVD, 32'h0);
    cpu_write("data_nostrb", A_DATA, 32'h99, 4'b0010);
    cpu_read("stat_after_nostrb", A_STAT, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("no_m_valid_idle", 32'(saw_valid), 32'd0);

    // ---- Three buffered writes against a slow slave ----
    slave_lat = 10;
    log_q.delete();
    cpu_write("wr_41", A_DATA, 32'h41, 4'b0001);
    cpu_write("wr_42", A_DATA, 32'h42, 4'b0001);
    cpu_write("wr_43", A_DATA, 32'h43, 4'b0001);
    wait_log("drain3_cnt", 3, 200);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain3_addr_%0d", i), log_q[i].addr, 32'h4);
      check($sformatf("drain3_data_%0d", i), log_q[i].wdata, 32'h41 + 32'(i));
      check($sformatf("drain3_strb_%0d", i), 32'(log_q[i].wstrb), 32'h1);
    end

    // ---- Fill to full, 17th write stalls, accepted in the pop cycle ----
    slave_hold = 1'b1;
    slave_lat  = 0;
    repeat (2) @(posedge clk);
    #1;
    log_q.delete();
    for (int i = 0; i < 16; i++) cpu_write($sformatf("fill_%0d", i), A_DATA, 32'h10 + 32'(i), 4'b0001);
    cpu_read("stat_full", A_STAT, 32'h42);
    s_mem_valid = 1'b1;
    s_mem_addr  = A_DATA;
    s_mem_wdata = 32'h30;
    s_mem_wstrb = 4'b0001;
    repeat (3) begin
      @(negedge clk);
      check("full_stall", 32'(s_mem_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    slave_hold = 1'b0;
    @(negedge clk);
    check("pop_accept_ready", 32'(s_mem_ready), 32'd1);
    check("pop_cycle_mready", 32'(m_mem_ready), 32'd1);
    @(posedge clk);
    #1;
    s_mem_valid = 1'b0;
    s_mem_wstrb = 4'b0000;
    slave_hold  = 1'b1;
    cpu_read("stat_still_full", A_STAT, 32'h42);
    slave_hold = 1'b0;
    wait_log("fill_drain_cnt", 17, 300);
    for (int i = 0; i < 16; i++)
      check($sformatf("fill_order_%0d", i), log_q[i].wdata, 32'h10 + 32'(i));
    check("fill_order_16", log_q[16].wdata, 32'h30);
    cpu_read("stat_drained", A_STAT, 32'h1);

    // ---- DIV write waits for the FIFO to drain ----
    slave_hold = 1'b1;
    log_q.delete();
    cpu_write("q_61", A_DATA, 32'h61, 4'b0001);
    cpu_write("q_62", A_DATA, 32'h62, 4'b0001);
    slave_lat  = 2;
    slave_hold = 1'b0;
    cpu_xfer("div_wr", A_DIV, 32'h1B2, 4'b1111, rd, w, mr);
    check("div_ready_with_mready", 32'(mr), 32'd1);
    check("div_log_cnt", 32'(log_q.size()), 32'd3);
    check("div_first_61", log_q[0].wdata, 32'h61);
    check("div_second_62", log_q[1].wdata, 32'h62);
    check("div_addr", log_q[2].addr, 32'h0);
    check("div_wdata", log_q[2].wdata, 32'h1B2);
    check("div_wstrb", 32'(log_q[2].wstrb), 32'hF);

    // ---- DATA read wins over a pending drain ----
    slave_lat   = 1;
    m_mem_rdata = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    log_q.delete();
    cpu_write("q_71", A_DATA, 32'h71, 4'b0001);
    cpu_xfer("data_rd", A_DATA, 32'h0, 4'b0000, rd, w, mr);
    check("data_rd_rdata", rd, 32'h55);
    check("data_rd_waits", 32'(w), 32'd2);
    wait_log("rd_drain_cnt", 2, 100);
    check("pass_first_strb", 32'(log_q[0].wstrb), 32'h0);
    check("pass_first_addr", log_q[0].addr, 32'h4);
    check("drain_after_pass", log_q[1].wdata, 32'h71);

    // ---- Reset in the middle of a drain ----
    slave_hold = 1'b1;
    for (int i = 0; i < 5; i++) cpu_write($sformatf("q5_%0d", i), A_DATA, 32'h81 + 32'(i), 4'b0001);
    @(negedge clk);
    check("mid_drain_valid", 32'(m_mem_valid), 32'd1);
    check("mid_drain_head", m_mem_wdata, 32'h81);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    log_q.delete();
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    saw_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(m_mem_valid), 32'd0);
    check("post_rst_wdata", m_mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    cpu_read("post_rst_stat", A_STAT, 32'h1);
    slave_hold = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_no_writes", 32'(log_q.size()), 32'd0);
    check("post_rst_no_valid", 32'(saw_valid), 32'd0);
    check("payload_stable", 32'(stab_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
